idma_pow2_burst_sequencer: RTL

Sequential front end that takes one 1-D transfer request (start address, byte length) and emits the full sequence of power-of-two-sized, page-bounded bursts covering it, one per valid/ready handshake. Each step's size comes from `idma_legalizer_pow2_splitter`, clamped to the page boundary. The block sits between the iDMA front end and the per-protocol request generator.

---
 rtl/idma_pow2_seq_pkg.sv | 18 +
 rtl/idma_legalizer_pow2_splitter.sv | 18 +
 rtl/idma_pow2_burst_sequencer.sv | 77 +++++++
 3 files changed

// File: rtl/idma_pow2_seq_pkg.sv
// idma_pow2_seq_pkg: shared types, default widths and helpers for the pow2 burst sequencer
package idma_pow2_seq_pkg;
  localparam int unsigned OffsetWidthDef   = 2;
  localparam int unsigned PageAddrWidthDef = 3;
  localparam int unsigned AddrWidthDef     = 32;
  localparam int unsigned LenWidthDef      = 32;
  typedef logic [AddrWidthDef-1:0]   addr_t;
  typedef logic [LenWidthDef-1:0]    len_t;
  typedef logic [PageAddrWidthDef:0] burst_len_t;
  typedef enum logic {IDLE, BURST} state_e;
  // Largest power of two not exceeding v; zero maps to zero.
  function automatic logic [31:0] flp2(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) if (v[i]) r = 32'(1) << i;
    return r;
  endfunction
endpackage

// File: rtl/idma_legalizer_pow2_splitter.sv
// idma_legalizer_pow2_splitter: largest power-of-two step that reaches no further than
// the next word boundary (unaligned) or a full page (aligned) and stays within the length
module idma_legalizer_pow2_splitter import idma_pow2_seq_pkg::*; #(
  parameter int unsigned OffsetWidth   = OffsetWidthDef,
  parameter int unsigned PageAddrWidth = PageAddrWidthDef
) (
  input  logic [OffsetWidth-1:0]   addr_i,
  input  logic [PageAddrWidth:0]   length_i,
  input  logic                     length_larger_i,
  output logic [PageAddrWidth:0]   bytes_o
);
  localparam int unsigned BW = PageAddrWidth + 1;
  logic [BW-1:0] w_word_left, w_lim, w_len;
  assign w_word_left = (BW'(1) << OffsetWidth) - BW'(addr_i);
  assign w_lim       = (addr_i == '0) ? (BW'(1) << PageAddrWidth) : w_word_left;
  assign w_len       = length_larger_i ? (BW'(1) << PageAddrWidth) : length_i;
  assign bytes_o     = BW'(flp2(32'(w_lim < w_len ? w_lim : w_len)));
endmodule

// File: rtl/idma_pow2_burst_sequencer.sv
// idma_pow2_burst_sequencer: walks one 1-D request as a series of power-of-two,
// page-bounded bursts, one per valid/ready handshake
module idma_pow2_burst_sequencer import idma_pow2_seq_pkg::*; #(
  parameter int unsigned OffsetWidth   = OffsetWidthDef,
  parameter int unsigned PageAddrWidth = PageAddrWidthDef,
  parameter int unsigned AddrWidth     = AddrWidthDef,
  parameter int unsigned LenWidth      = LenWidthDef
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [LenWidth-1:0]    req_length_i,
  output logic                   burst_valid_o,
  input  logic                   burst_ready_i,
  output logic [AddrWidth-1:0]   burst_addr_o,
  output logic [PageAddrWidth:0] burst_bytes_o,
  output logic                   burst_last_o,
  output logic                   busy_o,
  output logic                   done_o
);
  localparam int unsigned BW = PageAddrWidth + 1;
  state_e               r_state;
  logic [AddrWidth-1:0] r_addr;
  logic [LenWidth-1:0]  r_rem;
  logic                 r_done;
  logic [BW-1:0]        w_split_bytes, w_page_left, w_page_cap, w_bytes;
  logic                 w_last;
  idma_legalizer_pow2_splitter #(
    .OffsetWidth  (OffsetWidth),
    .PageAddrWidth(PageAddrWidth)
  ) u_splitter (
    .addr_i         (r_addr[OffsetWidth-1:0]),
    .length_i       (r_rem[PageAddrWidth:0]),
    .length_larger_i(|r_rem[LenWidth-1:PageAddrWidth+1]),
    .bytes_o        (w_split_bytes)
  );
  assign w_page_left = (BW'(1) << PageAddrWidth) - BW'(r_addr[PageAddrWidth-1:0]);
  assign w_page_cap  = BW'(flp2(32'(w_page_left)));
  assign w_bytes     = (w_split_bytes < w_page_cap) ? w_split_bytes : w_page_cap;
  // Gated by state so the idle registers (rem == bytes == 0) never flag a last burst.
  assign w_last      = (r_state == BURST) && (r_rem == LenWidth'(w_bytes));
  assign req_ready_o   = r_state == IDLE;
  assign busy_o        = r_state == BURST;
  assign burst_valid_o = r_state == BURST;
  assign burst_addr_o  = r_addr;
  assign burst_bytes_o = w_bytes;
  assign burst_last_o  = w_last;
  assign done_o        = r_done;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (req_valid_i && req_length_i == '0) begin
          r_done <= 1'b1;
        end else if (req_valid_i) begin
          r_addr  <= req_addr_i;
          r_rem   <= req_length_i;
          r_state <= BURST;
        end
      end else if (burst_ready_i) begin
        r_addr <= r_addr + AddrWidth'(w_bytes);
        r_rem  <= r_rem - LenWidth'(w_bytes);
        if (w_last) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
      end
    end
  end
endmodule
